// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences a PLL out of reset and supervises its lock. It pulses the PLL
//   reset, waits for lock (re-pulsing on timeout), and requires lock to hold
//   continuously for a qualification window before it releases the
//   downstream reset. It counts loss-of-lock events and relock timeouts.
//
// Parameters
//   PLL_RST_CYCLES     cycles pll_rst is held high per pulse (1..65535)
//   RELOCK_TIMEOUT     cycles waited for lock before re-pulsing (2..2^20-1)
//   LOCK_STABLE_CYCLES consecutive locked cycles before release (1..2^20-1)
//
// Ports
//   clkin          in   free-running reference clock, the only clock
//   rstn           in   synchronous active-low reset
//   locked         in   PLL lock indication, asynchronous to clkin
//   pll_rst        out  PLL reset, active-high
//   sys_rst_n      out  active-low reset for logic on the PLL clocks
//   lol_count      out  saturating loss-of-lock event count
//   timeout_count  out  saturating relock timeout count
//   state          out  0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUN
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned RELOCK_TIMEOUT     = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [7:0] lol_count,
  output logic [7:0] timeout_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [19:0] RST_LAST    = 20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(RELOCK_TIMEOUT - 1);
  localparam logic [19:0] STABLE_LAST = 20'(LOCK_STABLE_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       sync_p0;
  logic       lock_s;
  state_t     state_q;
  state_t     state_d;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic       lol_inc;
  logic       to_inc;
  logic [7:0] lol_q;
  logic [7:0] to_q;

  // Synchronizer stage boundary: locked -> sync_p0 -> lock_s
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_p0 <= locked;
      lock_s  <= sync_p0;
    end
  end

  // A captured low always wins over the terminal count, so a lock that
  // drops on the last qualification cycle never reaches RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lol_inc = 1'b0;
    to_inc  = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          to_inc  = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lol_inc = 1'b1;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // State register stage boundary
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      lol_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lol_inc) lol_q <= sat_inc(lol_q);
      if (to_inc)  to_q  <= sat_inc(to_q);
    end
  end

  assign pll_rst       = (state_q == RESET_PLL);
  assign sys_rst_n     = (state_q == RUN);
  assign state         = state_q;
  assign lol_count     = lol_q;
  assign timeout_count = to_q;

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset pulse, legal range 1..65535.
REQ-002 SHALL have parameter RELOCK_TIMEOUT, default 50000: cycles waited for lock before re-pulsing pll_rst (1 ms at 50 MHz), legal range 2..2^20-1.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release, legal range 1..2^20-1.
REQ-004 SHALL have port clkin, input, 1 bit: 50 MHz free-running reference clock, the only clock.
REQ-005 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port locked, input, 1 bit: PLL LOCK, asynchronous to clkin.
REQ-007 SHALL have port pll_rst, output, 1 bit: drives PLL RST, active-high.
REQ-008 SHALL have port sys_rst_n, output, 1 bit: active-low reset for logic on the PLL clocks.
REQ-009 SHALL have port lol_count, output, 8 bits: saturating loss-of-lock event count.
REQ-010 SHALL have port timeout_count, output, 8 bits: saturating count of relock timeouts.
REQ-011 SHALL have port state, output, 2 bits: encoding RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.

Function
REQ-012 SHALL pass locked through a 2-flop synchronizer to produce lock_s; both flops reset to 0; latency is 2 clkin edges.
REQ-013 SHALL implement a registered FSM with states RESET_PLL, WAIT_LOCK, STABILIZE and RUN, plus one shared 20-bit cycle counter cnt.
REQ-014 SHALL, in RESET_PLL: drive pll_rst=1; increment cnt each cycle; on cnt==PLL_RST_CYCLES-1 go to WAIT_LOCK and clear cnt.
REQ-015 SHALL, in WAIT_LOCK: drive pll_rst=0; if lock_s=1 go to STABILIZE and clear cnt.
REQ-016 SHALL, in WAIT_LOCK with lock_s=0: increment cnt; on cnt==RELOCK_TIMEOUT-1 go to RESET_PLL, clear cnt, and increment timeout_count.
REQ-017 SHALL, in STABILIZE: if lock_s=0 go to WAIT_LOCK and clear cnt.
REQ-018 SHALL, in STABILIZE with lock_s=1: increment cnt; on cnt==LOCK_STABLE_CYCLES-1 go to RUN.
REQ-019 SHALL, in RUN: if lock_s=0 go to WAIT_LOCK, clear cnt, and increment lol_count; otherwise remain in RUN.
REQ-020 SHALL make pll_rst=1 exactly when state==RESET_PLL and sys_rst_n=1 exactly when state==RUN, both decoded from the state register with no extra delay.
REQ-021 SHALL make lol_count and timeout_count saturate at 255, never wrapping.
REQ-022 SHALL give lock_s priority over the counter compare in STABILIZE: lock_s=0 on the terminal-count cycle returns to WAIT_LOCK.
REQ-023 SHALL ignore a lock glitch shorter than one clkin period if the synchronizer does not capture it; any captured low in STABILIZE or RUN restarts qualification.

Reset
REQ-024 SHALL, while rstn=0 at a clkin edge: state=RESET_PLL, cnt=0, lol_count=0, timeout_count=0, synchronizer=0, giving outputs pll_rst=1 and sys_rst_n=0.
REQ-025 SHALL, on reset asserted mid-operation (any state), return to RESET_PLL on the next edge and re-pulse the PLL for the full PLL_RST_CYCLES after release.

Verification (params PLL_RST_CYCLES=4, RELOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8)
REQ-026 SHALL cover: rstn released, locked held 1 -> pll_rst high 4 cycles, WAIT_LOCK 1 cycle, STABILIZE 8 cycles, then sys_rst_n=1 with state=3.
REQ-027 SHALL cover: locked held 0 -> pll_rst pulses 4 cycles every 24 cycles, and timeout_count counts 1, 2, 3, ... saturating at 255 after 255 timeouts.
REQ-028 SHALL cover: locked drops for 3 cycles at STABILIZE cnt=5 -> return to WAIT_LOCK, then a full 8-cycle qualification after relock, with lol_count unchanged.
REQ-029 SHALL cover: locked drops in RUN -> sys_rst_n=0 on the same edge state=1, and lol_count increments by 1; after 300 such drops lol_count=255.
REQ-030 SHALL cover: rstn=0 asserted while in RUN with lol_count=3 -> next edge state=0, pll_rst=1, sys_rst_n=0, and lol_count=0.
REQ-031 SHALL cover: locked=0 exactly on the STABILIZE terminal-count cycle -> state=WAIT_LOCK and sys_rst_n stays 0.
